gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
Sequencer for the binary-to-Gray datapath. It steps a W-bit binary index through a full code sweep, up or down, once or continuously, and converts each index to Gray through a bin2gray instance. Each code is offered to a downstream consumer over a valid/ready handshake. Typical consumers are position-encoder emulation and Gray-coded pointer test streams.

Parameters:
W, 3, width of binary index and Gray code (W >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
stop  input  1  abort request; honoured only in RUN
dir  input  1  0 = count up from 0, 1 = count down from 2^W-1; sampled only on accepted start
cont  input  1  0 = single sweep of 2^W codes, 1 = continuous wrap; sampled only on accepted start
out_ready  input  1  consumer accepts the current code
g_valid  output  1  g/b hold a valid code
g  output  W  registered Gray code, equal to bin2gray(b)
b  output  W  registered binary index matching g
busy  output  1  high in RUN
done  output  1  one-cycle pulse when a single sweep completes

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, g=0, b=0, g_valid=0, busy=0, done=0, emitted-count=0, latched dir/cont=0.
- Reset during a sweep aborts it immediately. No done pulse is produced.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: start=1 at edge n moves the FSM to RUN. At n+1 the outputs are g_valid=1, busy=1, b = 0 (up) or 2^W-1 (down), and g = bin2gray(b). dir and cont are latched at edge n. stop is ignored in IDLE.
- RUN, transfer rule: a transfer occurs at any edge where g_valid && out_ready.
- RUN, stalls: while g_valid && !out_ready, g and b hold their values exactly.
- RUN, on transfer: the next code appears the following cycle with no bubble. b advances by +1 (up) or -1 (down), modulo 2^W. emitted-count (W+1 bits) increments.
- RUN, single mode: the transfer of the 2^W-th code moves the FSM to DONE. On the following cycle g_valid=0, busy=0, done=1. g and b keep the last code.
- RUN, continuous mode: b wraps 2^W-1 -> 0 (up) or 0 -> 2^W-1 (down). emitted-count is not used to terminate. The sweep runs until stop.
- stop in RUN: the FSM goes to IDLE at that edge. The next cycle has g_valid=0, busy=0, done=0.
  - If a transfer occurs on the same edge, that transfer still counts as delivered; the FSM then goes to IDLE without advancing further.
  - stop on the same edge as the final single-mode transfer: stop wins. The FSM goes to IDLE and done is not asserted.
- start while busy or in DONE is ignored.
- DONE lasts exactly one cycle, then the FSM returns to IDLE. A start in the IDLE cycle after DONE is accepted.
- Gray rule: g[W-1] = b[W-1]; g[i] = b[i+1] ^ b[i] for i < W-1. Consecutive delivered codes differ in exactly one bit, including across the continuous-mode wrap.
- Throughput: with out_ready held high, one code per cycle. A single sweep occupies 2^W RUN cycles plus one DONE cycle.

Decomposition:
- Shared package contents:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - DIR_UP=1'b0, DIR_DOWN=1'b1
- One sub-module: bin2gray (parameter W, purely combinational, input b, output g).
  - Instantiate it on the next-b value so that g is registered alongside b.
  - The bench reuses bin2gray as its reference model.

Test Plan:
1. W=3, dir=0, cont=0, out_ready=1, start pulse -> g = 000,001,011,010,110,111,101,100 on 8 consecutive cycles; done=1 on the 9th cycle only; busy high for exactly 8 cycles.
2. W=3, dir=1, cont=0, out_ready=1 -> g = 100,101,111,110,010,011,001,000, then a done pulse.
3. Backpressure: up sweep, out_ready=0 for 3 cycles while g=010 (b=011) -> g/b held for 3 cycles; after ready rises, the next code is 110 with no skipped or duplicated codes; the total delivered count is still 8.
4. Continuous up, out_ready=1 -> after g=100 comes g=000 with no done pulse. Assert stop on the transfer of g=011 -> g_valid=0 next cycle; restart gives first code 000.
5. Edge conditions:
   - stop on the same edge as the 8th transfer -> done stays 0.
   - start while busy -> no effect on sequence.
   - dir toggled mid-sweep -> no effect.
6. rst=1 mid-sweep at g=111 -> next cycle all outputs 0, state IDLE. A subsequent start gives a clean sweep from 000.

Source files
------------

// File: rtl/gray_seq_ctrl_pkg.sv
// Shared types and constants for the Gray-code sequencer.
package gray_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Control and valid/ready code stream between the sequencer and its host/consumer.
interface gray_seq_ctrl_if #(parameter int W = 3);

    logic         start;
    logic         stop;
    logic         dir;
    logic         cont;
    logic         out_ready;
    logic         g_valid;
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic         busy;
    logic         done;

    // Sequencer side
    modport master (
        input  start, stop, dir, cont, out_ready,
        output g_valid, g, b, busy, done
    );

    // Host / consumer side
    modport slave (
        output start, stop, dir, cont, out_ready,
        input  g_valid, g, b, busy, done
    );

endinterface

// File: rtl/gray_seq_ctrl_bin2gray.sv
// Combinational binary-to-Gray converter: g[W-1] = b[W-1], g[i] = b[i+1] ^ b[i].
module bin2gray #(
    parameter int W = 3
) (
    input  logic [W-1:0] b,
    output logic [W-1:0] g
);

    assign g = b ^ (b >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Gray-code sweep sequencer: steps a binary index up or down through all
// 2^W codes (once or continuously) and offers each Gray code on valid/ready.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; no valid code
//   ST_RUN  | code on g/b is valid; advances on each accepted transfer
//   ST_DONE | single sweep finished; one-cycle done pulse, then IDLE
module gray_seq_ctrl
    import gray_seq_ctrl_pkg::*;
#(
    parameter int W = 3
) (
    input  logic            clk,
    input  logic            rst,
    gray_seq_ctrl_if.master bus
);

    localparam logic [W-1:0] B_ONES     = '1;
    localparam logic [W:0]   SWEEP_LAST = {1'b0, {W{1'b1}}};

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_b;
    logic [W-1:0]   w_b_nxt;
    logic [W-1:0]   r_g;
    logic [W-1:0]   w_g_nxt;
    logic [W-1:0]   w_b_step;
    logic [W:0]     r_cnt;
    logic [W:0]     w_cnt_nxt;
    logic           r_dir;
    logic           w_dir_nxt;
    logic           r_cont;
    logic           w_cont_nxt;
    logic           w_xfer;

    assign w_xfer   = (r_state == ST_RUN) && bus.out_ready;
    assign w_b_step = (r_dir == DIR_UP) ? (r_b + 1'b1) : (r_b - 1'b1);

    // Gray is computed from the next index so g is registered together with b.
    bin2gray #(.W(W)) u_bin2gray (
        .b (w_b_nxt),
        .g (w_g_nxt)
    );

    // Next-state, next-index and sweep bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_cont_nxt  = r_cont;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_dir_nxt   = bus.dir;
                    w_cont_nxt  = bus.cont;
                    w_cnt_nxt   = '0;
                    w_b_nxt     = (bus.dir == DIR_DOWN) ? B_ONES : '0;
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                // stop takes priority; a coincident transfer is still counted
                // but the index does not advance.
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_xfer) begin
                    if (!r_cont && (r_cnt == SWEEP_LAST)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_b_nxt = w_b_step;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_b     <= '0;
            r_g     <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_cont  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_b     <= w_b_nxt;
            r_g     <= w_g_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_cont  <= w_cont_nxt;
        end
    end

    assign bus.g_valid = (r_state == ST_RUN);
    assign bus.busy    = (r_state == ST_RUN);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.g       = r_g;
    assign bus.b       = r_b;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl (W=3): table-driven sweeps plus
// hand-written corner sequences, with a scoreboard of expected codes.
module tb_gray_seq_ctrl;
    import gray_seq_ctrl_pkg::*;

    localparam int W = 3;
    localparam int N = 1 << W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_seq_ctrl_if #(.W(W)) bus ();

    gray_seq_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference Gray codes for every index, from the shared converter.
    wire [W-1:0] ref_g [N];
    for (genvar k = 0; k < N; k++) begin : g_ref
        localparam logic [W-1:0] KB = W'(k);
        bin2gray #(.W(W)) u_ref (.b(KB), .g(ref_g[k]));
    end

    typedef struct packed {
        logic [W-1:0] b;
        logic [W-1:0] g;
    } exp_t;

    typedef struct {
        logic           dir;
        logic [W*N-1:0] gseq;
    } vec_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    vec_t   vecs[2];
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_xfer   = 0;
    int     x0;
    logic [W-1:0] prev_g;
    logic [W-1:0] held_g;
    logic [W-1:0] held_b;
    logic [W-1:0] tcode;
    logic         have_prev;
    logic         stall_prev;
    logic         found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_code(input int bval);
        exp_q.push_back({W'(bval), ref_g[bval]});
    endtask

    task automatic push_sweep(input int first, input int last);
        for (int i = first; i <= last; i++) push_code(i);
    endtask

    task automatic do_start(input logic d, input logic c);
        bus.start = 1'b1;
        bus.dir   = d;
        bus.cont  = c;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        found = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("done_seen", found, 1);
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_g_valid"}, bus.g_valid, 0);
        check({tag, "_busy"},    bus.busy,    0);
        check({tag, "_done"},    bus.done,    0);
    endtask

    // Scoreboard consumer: pops one expected code per observed transfer and
    // checks stall hold and single-bit steps between delivered codes.
    task automatic monitor();
        have_prev  = 1'b0;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || bus.g_valid !== 1'b1) begin
                have_prev = 1'b0;
            end
            if (rst === 1'b0 && stall_prev) begin
                check("stall_hold_g", bus.g, held_g);
                check("stall_hold_b", bus.b, held_b);
            end
            if (rst === 1'b0 && bus.g_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", bus.b, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("xfer_b", bus.b, mon_e.b);
                    check("xfer_g", bus.g, mon_e.g);
                end
                if (have_prev) check("one_bit_step", $countones(bus.g ^ prev_g), 1);
                prev_g    = bus.g;
                have_prev = 1'b1;
            end
            stall_prev = (rst === 1'b0) && (bus.g_valid === 1'b1) && (bus.out_ready === 1'b0);
            held_g     = bus.g;
            held_b     = bus.b;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].dir  = DIR_UP;
        vecs[0].gseq = {3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        vecs[1].dir  = DIR_DOWN;
        vecs[1].gseq = {3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.dir       = 1'b0;
        bus.cont      = 1'b0;
        bus.out_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_g", bus.g, 0);
        check("reset_b", bus.b, 0);
        check_idle_outputs("reset");
        tick();

        // Single sweeps from the table, up then down.
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < N; i++) begin
                tcode = vecs[v].gseq[W*(N-1-i) +: W];
                exp_q.push_back({(vecs[v].dir ? W'(N-1-i) : W'(i)), tcode});
            end
            x0 = n_xfer;
            do_start(vecs[v].dir, 1'b0);
            for (int i = 0; i < N; i++) begin
                @(negedge clk);
                check("tbl_busy", bus.busy, 1);
                check("tbl_done_early", bus.done, 0);
                tick();
            end
            @(negedge clk);
            tcode = vecs[v].gseq[W-1:0];
            check("tbl_done", bus.done, 1);
            check("tbl_busy_off", bus.busy, 0);
            check("tbl_valid_off", bus.g_valid, 0);
            check("tbl_g_kept", bus.g, tcode);
            tick();
            @(negedge clk);
            check("tbl_done_one_cycle", bus.done, 0);
            check("tbl_xfers", n_xfer - x0, N);
            check("tbl_q_empty", exp_q.size(), 0);
            tick();
        end

        // Backpressure at g=010 (b=3) for three cycles.
        push_sweep(0, N-1);
        x0 = n_xfer;
        do_start(DIR_UP, 1'b0);
        repeat (3) tick();
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_b", bus.b, 3);
            check("bp_g", bus.g, 3'b010);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_done(20);
        check("bp_xfers", n_xfer - x0, N);
        check("bp_q_empty", exp_q.size(), 0);

        // Continuous up: wrap without done, stop on transfer of g=011.
        push_sweep(0, N-1);
        push_sweep(0, 2);
        do_start(DIR_UP, 1'b1);
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clk);
            check("cont_no_done", bus.done, 0);
            tick();
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        @(negedge clk);
        check_idle_outputs("cont_stop");
        check("cont_q_empty", exp_q.size(), 0);
        tick();
        push_sweep(0, N-1);
        do_start(DIR_UP, 1'b0);
        @(negedge clk);
        check("restart_first_g", bus.g, 0);
        wait_done(20);
        check("restart_q_empty", exp_q.size(), 0);

        // Stop coincident with the final transfer suppresses done.
        push_sweep(0, N-1);
        do_start(DIR_UP, 1'b0);
        repeat (N-1) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("laststop_done", bus.done, 0);
            check("laststop_valid", bus.g_valid, 0);
            tick();
        end
        check("laststop_q_empty", exp_q.size(), 0);

        // start, dir and cont changes mid-sweep are ignored.
        push_sweep(0, N-1);
        x0 = n_xfer;
        do_start(DIR_UP, 1'b0);
        repeat (2) tick();
        bus.start = 1'b1;
        bus.dir   = 1'b1;
        bus.cont  = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(20);
        check("midchg_xfers", n_xfer - x0, N);
        check("midchg_q_empty", exp_q.size(), 0);
        bus.dir  = 1'b0;
        bus.cont = 1'b0;

        // Reset mid-sweep at g=111, then a clean sweep.
        push_sweep(0, 5);
        do_start(DIR_UP, 1'b0);
        repeat (5) tick();
        @(negedge clk);
        check("rst_pre_g", bus.g, 3'b111);
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_g", bus.g, 0);
        check("rst_b", bus.b, 0);
        check_idle_outputs("rst");
        check("rst_q_empty", exp_q.size(), 0);
        tick();
        push_sweep(0, N-1);
        x0 = n_xfer;
        do_start(DIR_UP, 1'b0);
        wait_done(20);
        check("post_rst_xfers", n_xfer - x0, N);
        check("post_rst_q_empty", exp_q.size(), 0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
